// File: rtl/sd_tx_fifo_filler_pkg.sv
// Shared definitions for the SD TX FIFO filler: FSM states, completion status codes and TX FIFO depth.
package sd_tx_fifo_filler_pkg;

   localparam int FIFO_TX_MEM_DEPTH = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_SPACE,
      ST_BURST,
      ST_GAP,
      ST_FINISH
   } fill_state_e;

   localparam logic [1:0] STAT_OK     = 2'b00;
   localparam logic [1:0] STAT_BUSERR = 2'b01;
   localparam logic [1:0] STAT_ABORT  = 2'b10;

   // Little-endian host word to MSB-first serializer order.
   function automatic logic [31:0] byte_swap32(input logic [31:0] d);
      return {d[7:0], d[15:8], d[23:16], d[31:24]};
   endfunction

endpackage

// File: rtl/sd_tx_fifo_filler_space_chk.sv
// Free-space comparator: asserts space_ok when a burst of 'need' words is guaranteed to fit in the TX FIFO.
module sd_fill_space_chk #(
   parameter int FIFO_DEPTH = 16,
   parameter int LVL_W      = 6
) (
   input  logic [LVL_W-1:0] fifo_lvl,
   input  logic             fifo_full,
   input  logic [LVL_W:0]   need,
   output logic             space_ok
);

   logic [LVL_W:0] free_words;

   // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
   always_comb begin
      free_words = (LVL_W+1)'(FIFO_DEPTH) - {1'b0, fifo_lvl};
      space_ok   = !fifo_full && (free_words >= need);
   end

endmodule

// File: rtl/sd_tx_fifo_filler.sv
// Wishbone read-burst sequencer filling the SD TX FIFO (wclk domain).
// Optional byte reversal of written words when SD_TX_FILL_SWAP_EN is defined.
module sd_tx_fifo_filler
   import sd_tx_fifo_filler_pkg::*;
#(
   parameter int FIFO_DEPTH = FIFO_TX_MEM_DEPTH,
   parameter int BURST_LEN  = 4,
   parameter int LEN_W      = 16,
   parameter int LVL_W      = 6
) (
   input  logic             wclk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [31:0]      base_adr,
   input  logic [LEN_W-1:0] word_cnt,
   output logic             busy,
   output logic             done,
   output logic [1:0]       status,
   output logic             m_wb_cyc_o,
   output logic             m_wb_stb_o,
   output logic             m_wb_we_o,
   output logic [3:0]       m_wb_sel_o,
   output logic [31:0]      m_wb_adr_o,
   input  logic [31:0]      m_wb_dat_i,
   input  logic             m_wb_ack_i,
   input  logic             m_wb_err_i,
   output logic [31:0]      fifo_d,
   output logic             fifo_wr,
   input  logic             fifo_full,
   input  logic [LVL_W-1:0] fifo_lvl
);

   localparam int NEED_W = LVL_W + 1;

   fill_state_e      state_q, state_d;
   logic [31:0]      adr_q, adr_d;
   logic [LEN_W-1:0] rem_q, rem_d;
   logic [NEED_W-1:0] bcnt_q, bcnt_d;
   logic [NEED_W-1:0] need_q, need_d;
   logic [1:0]       status_q, status_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             cyc_q, cyc_d;

   logic [NEED_W-1:0] need_now;
   logic [NEED_W-1:0] bcnt_inc;
   logic              space_ok;
   logic              in_burst;
   logic              ack_ok;
   logic [31:0]       wr_data;

   assign need_now = (rem_q >= LEN_W'(BURST_LEN)) ? NEED_W'(BURST_LEN) : rem_q[NEED_W-1:0];
   assign bcnt_inc = bcnt_q + NEED_W'(1);
   assign in_burst = (state_q == ST_BURST);
   assign ack_ok   = m_wb_ack_i && !m_wb_err_i;

   sd_fill_space_chk #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .LVL_W      (LVL_W)
   ) u_space_chk (
      .fifo_lvl  (fifo_lvl),
      .fifo_full (fifo_full),
      .need      (need_now),
      .space_ok  (space_ok)
   );

   always_comb begin
      state_d  = state_q;
      adr_d    = adr_q;
      rem_d    = rem_q;
      bcnt_d   = bcnt_q;
      need_d   = need_q;
      status_d = status_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               adr_d    = base_adr & ~32'h3;
               rem_d    = word_cnt;
               status_d = STAT_OK;
               state_d  = (word_cnt == '0) ? ST_FINISH : ST_WAIT_SPACE;
            end
         end
         ST_WAIT_SPACE: begin
            if (abort) begin
               status_d = STAT_ABORT;
               state_d  = ST_FINISH;
            end else if (space_ok) begin
               need_d  = need_now;
               bcnt_d  = '0;
               state_d = ST_BURST;
            end
         end
         ST_BURST: begin
            // A bus error discards the beat and every remaining word.
            if (m_wb_err_i) begin
               status_d = STAT_BUSERR;
               state_d  = ST_FINISH;
            end else begin
               if (m_wb_ack_i) begin
                  adr_d  = adr_q + 32'd4;
                  rem_d  = rem_q - LEN_W'(1);
                  bcnt_d = bcnt_inc;
               end
               if (abort) begin
                  status_d = STAT_ABORT;
                  state_d  = ST_FINISH;
               end else if (m_wb_ack_i && (bcnt_inc == need_q || rem_q == LEN_W'(1))) begin
                  state_d = ST_GAP;
               end
            end
         end
         ST_GAP: begin
            if (abort) begin
               status_d = STAT_ABORT;
               state_d  = ST_FINISH;
            end else begin
               state_d = (rem_q == '0) ? ST_FINISH : ST_WAIT_SPACE;
            end
         end
         ST_FINISH: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_FINISH);
      cyc_d  = (state_d == ST_BURST);
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge wclk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         adr_q    <= '0;
         rem_q    <= '0;
         bcnt_q   <= '0;
         need_q   <= '0;
         status_q <= STAT_OK;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         cyc_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         adr_q    <= adr_d;
         rem_q    <= rem_d;
         bcnt_q   <= bcnt_d;
         need_q   <= need_d;
         status_q <= status_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         cyc_q    <= cyc_d;
      end
   end

`ifdef SD_TX_FILL_SWAP_EN
   assign wr_data = byte_swap32(m_wb_dat_i);
`else
   assign wr_data = m_wb_dat_i;
`endif

   // Zero-latency write on ack; the full flag is a belt-and-braces guard.
   assign fifo_wr = in_burst && ack_ok && !fifo_full;
   assign fifo_d  = in_burst ? wr_data : 32'h0;

   assign busy       = busy_q;
   assign done       = done_q;
   assign status     = status_q;
   assign m_wb_cyc_o = cyc_q;
   assign m_wb_stb_o = cyc_q;
   assign m_wb_we_o  = 1'b0;
   assign m_wb_sel_o = 4'hF;
   assign m_wb_adr_o = adr_q;

endmodule

// File: tb/tb_sd_tx_fifo_filler.sv
// Self-checking bench for sd_tx_fifo_filler: table of complete transfers plus hand sequences for
// space stalls, bus error, abort, reset mid-burst and the optional byte swap.
module tb_sd_tx_fifo_filler;

   logic        wclk;
   logic        rst;
   logic        start;
   logic        abort;
   logic [31:0] base_adr;
   logic [15:0] word_cnt;
   logic        busy;
   logic        done;
   logic [1:0]  status;
   logic        m_wb_cyc_o;
   logic        m_wb_stb_o;
   logic        m_wb_we_o;
   logic [3:0]  m_wb_sel_o;
   logic [31:0] m_wb_adr_o;
   logic [31:0] m_wb_dat_i;
   logic        m_wb_ack_i;
   logic        m_wb_err_i;
   logic [31:0] fifo_d;
   logic        fifo_wr;
   logic        fifo_full;
   logic [5:0]  fifo_lvl;

   sd_tx_fifo_filler dut (
      .wclk       (wclk),
      .rst        (rst),
      .start      (start),
      .abort      (abort),
      .base_adr   (base_adr),
      .word_cnt   (word_cnt),
      .busy       (busy),
      .done       (done),
      .status     (status),
      .m_wb_cyc_o (m_wb_cyc_o),
      .m_wb_stb_o (m_wb_stb_o),
      .m_wb_we_o  (m_wb_we_o),
      .m_wb_sel_o (m_wb_sel_o),
      .m_wb_adr_o (m_wb_adr_o),
      .m_wb_dat_i (m_wb_dat_i),
      .m_wb_ack_i (m_wb_ack_i),
      .m_wb_err_i (m_wb_err_i),
      .fifo_d     (fifo_d),
      .fifo_wr    (fifo_wr),
      .fifo_full  (fifo_full),
      .fifo_lvl   (fifo_lvl)
   );

   initial wclk = 1'b0;
   always #5 wclk = ~wclk;

   int checks   = 0;
   int failures = 0;

   // Slave/monitor state
   int          beat;
   int          err_at;
   int          abort_at;
   int          wr_cnt;
   int          burst_cnt;
   int          last_len;
   int          done_cnt;
   int          dat_err;
   int          full_viol;
   logic        cyc_prev;
   logic [31:0] first_adr;
   logic [31:0] last_adr;
   logic [31:0] last_d;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h3000) return 32'h1122_3344;
      return a ^ 32'h5A5A_0000;
   endfunction

   function automatic logic [31:0] exp_fifo(input logic [31:0] a);
      logic [31:0] w;
      w = mem_word(a);
`ifdef SD_TX_FILL_SWAP_EN
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
      return w;
`endif
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Zero-wait Wishbone slave plus write monitor, sampled away from the rising edge.
   initial begin
      m_wb_ack_i = 1'b0;
      m_wb_err_i = 1'b0;
      m_wb_dat_i = 32'h0;
      abort      = 1'b0;
      cyc_prev   = 1'b0;
      forever begin
         @(negedge wclk);
         m_wb_ack_i = 1'b0;
         m_wb_err_i = 1'b0;
         abort      = 1'b0;
         if (m_wb_cyc_o && m_wb_stb_o) begin
            m_wb_dat_i = mem_word(m_wb_adr_o);
            if (beat == err_at) m_wb_err_i = 1'b1;
            else                m_wb_ack_i = 1'b1;
            if (beat == abort_at) abort = 1'b1;
            beat++;
         end
         #1;
         if (m_wb_cyc_o && !cyc_prev) begin
            burst_cnt++;
            if (burst_cnt == 1) first_adr = m_wb_adr_o;
            last_adr = m_wb_adr_o;
            last_len = 0;
         end
         cyc_prev = m_wb_cyc_o;
         if (fifo_wr) begin
            wr_cnt++;
            last_len++;
            last_d = fifo_d;
            if (fifo_d !== exp_fifo(m_wb_adr_o)) dat_err++;
            if (fifo_full) full_viol++;
         end
         if (done) done_cnt++;
      end
   end

   task automatic clear_mon();
      beat      = 0;
      err_at    = -1;
      abort_at  = -1;
      wr_cnt    = 0;
      burst_cnt = 0;
      last_len  = 0;
      done_cnt  = 0;
      dat_err   = 0;
      first_adr = 32'h0;
      last_adr  = 32'h0;
      last_d    = 32'h0;
   endtask

   task automatic start_xfer(input logic [31:0] adr, input logic [15:0] cnt);
      @(negedge wclk);
      base_adr = adr;
      word_cnt = cnt;
      start    = 1'b1;
      @(negedge wclk);
      start    = 1'b0;
   endtask

   task automatic wait_done(input string name);
      for (int i = 0; i < 300; i++) begin
         @(negedge wclk);
         #2;
         if (done_cnt != 0) break;
      end
      check(name, 32'(done_cnt != 0), 32'd1);
   endtask

   typedef struct {
      logic [31:0] base;
      logic [15:0] cnt;
      logic [5:0]  lvl;
      int          wr;
      int          bursts;
      logic [31:0] first_adr;
      logic [31:0] last_adr;
      int          last_len;
      logic [1:0]  st;
   } vec_t;

   vec_t vecs[7];

   initial begin
      vecs[0] = '{32'h0000_1000, 16'd10, 6'd0,  10, 3, 32'h0000_1000, 32'h0000_1020, 2, 2'b00};
      vecs[1] = '{32'h0000_2003, 16'd3,  6'd0,  3,  1, 32'h0000_2000, 32'h0000_2000, 3, 2'b00};
      vecs[2] = '{32'hFFFF_FFF8, 16'd5,  6'd0,  5,  2, 32'hFFFF_FFF8, 32'h0000_0008, 1, 2'b00};
      vecs[3] = '{32'h0000_0040, 16'd1,  6'd12, 1,  1, 32'h0000_0040, 32'h0000_0040, 1, 2'b00};
      vecs[4] = '{32'h0000_0080, 16'd4,  6'd12, 4,  1, 32'h0000_0080, 32'h0000_0080, 4, 2'b00};
      vecs[5] = '{32'h0000_0090, 16'd6,  6'd12, 6,  2, 32'h0000_0090, 32'h0000_00A0, 2, 2'b00};
      vecs[6] = '{32'h0000_0500, 16'd0,  6'd0,  0,  0, 32'h0000_0000, 32'h0000_0000, 0, 2'b00};

      rst       = 1'b1;
      start     = 1'b0;
      base_adr  = 32'h0;
      word_cnt  = 16'h0;
      fifo_full = 1'b0;
      fifo_lvl  = 6'd0;
      full_viol = 0;
      clear_mon();

      repeat (3) @(negedge wclk);
      #2;
      check("rst_cyc",    32'(m_wb_cyc_o), 32'd0);
      check("rst_busy",   32'(busy),       32'd0);
      check("rst_done",   32'(done),       32'd0);
      check("rst_status", 32'(status),     32'd0);
      check("rst_adr",    m_wb_adr_o,      32'h0);
      check("rst_sel",    32'(m_wb_sel_o), 32'hF);
      check("rst_we",     32'(m_wb_we_o),  32'd0);
      @(negedge wclk);
      rst = 1'b0;

      for (int v = 0; v < 7; v++) begin
         clear_mon();
         fifo_lvl = vecs[v].lvl;
         start_xfer(vecs[v].base, vecs[v].cnt);
         wait_done($sformatf("v%0d_done", v));
         repeat (3) @(negedge wclk);
         #2;
         check($sformatf("v%0d_wr", v),        32'(wr_cnt),    32'(vecs[v].wr));
         check($sformatf("v%0d_bursts", v),    32'(burst_cnt), 32'(vecs[v].bursts));
         check($sformatf("v%0d_first_adr", v), first_adr,      vecs[v].first_adr);
         check($sformatf("v%0d_last_adr", v),  last_adr,       vecs[v].last_adr);
         check($sformatf("v%0d_last_len", v),  32'(last_len),  32'(vecs[v].last_len));
         check($sformatf("v%0d_status", v),    32'(status),    32'(vecs[v].st));
         check($sformatf("v%0d_one_done", v),  32'(done_cnt),  32'd1);
         check($sformatf("v%0d_data", v),      32'(dat_err),   32'd0);
         check($sformatf("v%0d_idle", v),      32'(busy),      32'd0);
      end

      // Space stall: 2 free < 4, 3 free < 4, full flag, then exactly 4 free.
      clear_mon();
      fifo_lvl = 6'd14;
      start_xfer(32'h6000, 16'd4);
      repeat (8) @(negedge wclk);
      #2;
      check("stall14_cyc",  32'(m_wb_cyc_o), 32'd0);
      check("stall14_busy", 32'(busy),       32'd1);
      fifo_lvl = 6'd13;
      start_xfer(32'h7000, 16'd4);
      repeat (4) @(negedge wclk);
      #2;
      check("stall13_bursts", 32'(burst_cnt), 32'd0);
      fifo_lvl  = 6'd0;
      fifo_full = 1'b1;
      repeat (4) @(negedge wclk);
      #2;
      check("stall_full_bursts", 32'(burst_cnt), 32'd0);
      fifo_full = 1'b0;
      fifo_lvl  = 6'd12;
      wait_done("stall_done");
      check("stall_wr",     32'(wr_cnt),    32'd4);
      check("stall_first",  first_adr,      32'h6000);
      check("stall_bursts", 32'(burst_cnt), 32'd1);
      fifo_lvl = 6'd0;

      // Bus error on the second beat.
      clear_mon();
      err_at = 1;
      start_xfer(32'h8000, 16'd8);
      for (int i = 0; i < 50; i++) begin
         @(negedge wclk);
         #2;
         if (m_wb_err_i) break;
      end
      check("err_seen", 32'(m_wb_err_i), 32'd1);
      @(posedge wclk);
      #1;
      check("err_cyc_drop", 32'(m_wb_cyc_o), 32'd0);
      check("err_done",     32'(done),       32'd1);
      wait_done("err_done_seen");
      check("err_wr",     32'(wr_cnt), 32'd1);
      check("err_status", 32'(status), 32'd1);

      // Abort together with the second ack.
      clear_mon();
      abort_at = 1;
      start_xfer(32'h9000, 16'd8);
      for (int i = 0; i < 50; i++) begin
         @(negedge wclk);
         #2;
         if (abort) break;
      end
      check("abort_seen", 32'(abort && m_wb_ack_i), 32'd1);
      @(posedge wclk);
      #1;
      check("abort_cyc_drop", 32'(m_wb_cyc_o), 32'd0);
      wait_done("abort_done_seen");
      check("abort_wr",     32'(wr_cnt), 32'd2);
      check("abort_status", 32'(status), 32'd2);

      // New start after abort; also the byte-order check.
      clear_mon();
      start_xfer(32'h3000, 16'd1);
      wait_done("restart_done");
      check("restart_status", 32'(status), 32'd0);
      check("restart_wr",     32'(wr_cnt), 32'd1);
`ifdef SD_TX_FILL_SWAP_EN
      check("swap_data", last_d, 32'h4433_2211);
`else
      check("swap_data", last_d, 32'h1122_3344);
`endif

      // Asynchronous reset mid-burst.
      clear_mon();
      start_xfer(32'hA000, 16'd8);
      for (int i = 0; i < 50; i++) begin
         @(negedge wclk);
         #2;
         if (m_wb_cyc_o) break;
      end
      check("rst_mid_cyc_before", 32'(m_wb_cyc_o), 32'd1);
      rst = 1'b1;
      #1;
      check("rst_mid_cyc",  32'(m_wb_cyc_o), 32'd0);
      check("rst_mid_busy", 32'(busy),       32'd0);
      check("rst_mid_wr",   32'(fifo_wr),    32'd0);
      check("rst_mid_adr",  m_wb_adr_o,      32'h0);
      @(negedge wclk);
      rst = 1'b0;
      repeat (10) @(negedge wclk);
      #2;
      check("rst_mid_no_done", 32'(done_cnt), 32'd0);
      check("rst_mid_idle",    32'(busy),     32'd0);

      check("never_write_full", 32'(full_viol), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
